// File: rtl/opti_divider.sv
// Signed Q2.22 divider: p = a / b, rounded half away from zero and saturated.
// Fixed 28-cycle operation using a 25-step radix-2 restoring divide on magnitudes.
module opti_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        valid_in,
    output logic        ready,
    output logic [23:0] p,
    output logic        valid_out,
    output logic        div_zero
);

    localparam logic [23:0] Q22Max = 24'h3FFFFF;
    localparam logic [23:0] Q22Min = 24'hC00000;

    typedef enum logic [1:0] {StIdle, StPrep, StDiv, StRound} state_e;

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic        a_neg_q, a_neg_d;
    logic [23:0] abs_a_q, abs_a_d;
    logic [23:0] abs_b_q, abs_b_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] rem_q, rem_d;
    logic [24:0] quot_q, quot_d;
    logic [23:0] p_q, p_d;
    logic        vout_q, vout_d;
    logic        dz_q, dz_d;

    logic [24:0] rem_sh;
    logic        sub_ok;
    logic [24:0] qm;

    // quot_q holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
    assign rem_sh = {rem_q, quot_q[24]};
    assign sub_ok = rem_sh >= {1'b0, abs_b_q};
    // (Q25 + 1) >> 1 without needing a 26-bit adder.
    assign qm     = {1'b0, quot_q[24:1]} + {24'd0, quot_q[0]};

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        a_neg_d = a_neg_q;
        abs_a_d = abs_a_q;
        abs_b_d = abs_b_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        p_d     = p_q;
        dz_d    = dz_q;
        vout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    state_d = StPrep;
                    sign_d  = a[23] ^ b[23];
                    a_neg_d = a[23];
                    abs_a_d = a[23] ? (24'd0 - a) : a;
                    abs_b_d = b[23] ? (24'd0 - b) : b;
                end
            end
            StPrep: begin
                zero_d  = (abs_b_q == 24'd0);
                ovf_d   = {2'b00, abs_a_q} >= {abs_b_q, 2'b00};
                cnt_d   = 5'd24;
                rem_d   = {2'b00, abs_a_q[23:2]};
                quot_d  = {abs_a_q[1:0], 23'd0};
                state_d = StDiv;
            end
            StDiv: begin
                rem_d  = sub_ok ? (rem_sh[23:0] - abs_b_q) : rem_sh[23:0];
                quot_d = {quot_q[23:0], sub_ok};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (zero_q) begin
                    p_d = a_neg_q ? Q22Min : Q22Max;
                end else if (ovf_q) begin
                    p_d = sign_q ? Q22Min : Q22Max;
                end else if (!sign_q) begin
                    p_d = (qm > 25'h3FFFFF) ? Q22Max : qm[23:0];
                end else begin
                    p_d = (qm > 25'h400000) ? Q22Min : (24'd0 - qm[23:0]);
                end
                dz_d    = zero_q;
                vout_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            a_neg_q <= 1'b0;
            abs_a_q <= 24'd0;
            abs_b_q <= 24'd0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 5'd0;
            rem_q   <= 24'd0;
            quot_q  <= 25'd0;
            p_q     <= 24'd0;
            vout_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            a_neg_q <= a_neg_d;
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            p_q     <= p_d;
            vout_q  <= vout_d;
            dz_q    <= dz_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign p         = p_q;
    assign valid_out = vout_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_opti_divider.sv
// Bench for opti_divider: cycle-level arithmetic model checked every cycle,
// plus directed operations with hand-computed quotients.
module tb_opti_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] a;
    logic [23:0] b;
    logic        valid_in;
    logic        ready;
    logic [23:0] p;
    logic        valid_out;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    opti_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .valid_in (valid_in),
        .ready    (ready),
        .p        (p),
        .valid_out(valid_out),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {div_zero, p}: round(a/b) half away from zero, clamped to Q2.22.
    function automatic logic [24:0] model_div(input logic [23:0] av, input logic [23:0] bv);
        longint sa, sb, ua, ub, qm, v;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (sb == 0) return {1'b1, (sa >= 0) ? 24'h3FFFFF : 24'hC00000};
        ua = (sa < 0) ? -sa : sa;
        ub = (sb < 0) ? -sb : sb;
        qm = (ua * 64'd8388608 + ub) / (2 * ub);
        v  = ((sa < 0) != (sb < 0)) ? -qm : qm;
        if (v > 64'sd4194303) v = 64'sd4194303;
        if (v < -64'sd4194304) v = -64'sd4194304;
        return {1'b0, v[23:0]};
    endfunction

    // Model: an accepted request completes 27 cycles later; nothing accepted while busy.
    int          m_busy = 0;
    logic        m_live = 1'b0;
    logic        m_vout, m_dz, m_pend_dz;
    logic [23:0] m_p, m_pend_p;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_vout <= 1'b0;
            m_p    <= 24'd0;
            m_dz   <= 1'b0;
            m_live <= 1'b1;
        end else if (m_busy == 0) begin
            m_vout <= 1'b0;
            if (valid_in) begin
                {m_pend_dz, m_pend_p} <= model_div(a, b);
                m_busy <= 27;
            end
        end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_vout <= 1'b1;
                m_p    <= m_pend_p;
                m_dz   <= m_pend_dz;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ready", {31'd0, ready}, {31'd0, m_busy == 0});
            check("valid_out", {31'd0, valid_out}, {31'd0, m_vout});
            check("p", {8'd0, p}, {8'd0, m_p});
            check("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
        end
    end

    task automatic run_op(input string name, input logic [23:0] av, input logic [23:0] bv,
                          input logic [23:0] exp_p, input logic exp_dz);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        a = av;
        b = bv;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (!valid_out && n < 40) begin
            @(negedge clk);
            n++;
            // Requests while busy must be dropped without disturbing the operation.
            if (n == 5) valid_in = 1'b1;
            if (n == 8) valid_in = 1'b0;
        end
        valid_in = 1'b0;
        check({name, "_latency"}, n, 27);
        check({name, "_p"}, {8'd0, p}, {8'd0, exp_p});
        check({name, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        a        = 24'd0;
        b        = 24'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_p", {8'd0, p}, 32'd0);
        check("rst_vout", {31'd0, valid_out}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("half",     24'h200000, 24'h400000, 24'h200000, 1'b0);
        run_op("neg_qtr",  24'h100000, 24'hC00000, 24'hF00000, 1'b0);
        run_op("rnd_up",   24'h200000, 24'h300000, 24'h2AAAAB, 1'b0);
        run_op("rnd_dn",   24'h100000, 24'h300000, 24'h155555, 1'b0);
        run_op("sat_pos",  24'h400000, 24'h200000, 24'h3FFFFF, 1'b0);
        run_op("neg_one",  24'h400000, 24'hC00000, 24'hC00000, 1'b0);
        run_op("ovf_neg",  24'h800000, 24'h000001, 24'hC00000, 1'b0);
        run_op("dz_neg",   24'hE00000, 24'h000000, 24'hC00000, 1'b1);
        run_op("dz_zero",  24'h000000, 24'h000000, 24'h3FFFFF, 1'b1);
        run_op("zero_num", 24'h000000, 24'hC00000, 24'h000000, 1'b0);
        run_op("m1_by_1",  24'hC00000, 24'h400000, 24'hC00000, 1'b0);
        run_op("one_sat",  24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 1'b0);

        // valid_in held high with changing operands: one accept per 28 cycles.
        while (!ready) @(negedge clk);
        valid_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 84; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            if (valid_out) pulses++;
        end
        valid_in = 1'b0;
        check("stream_pulses", pulses, 3);

        // Reset pulse during DIV iteration 10 aborts the operation.
        while (!ready) @(negedge clk);
        a = 24'h200000;
        b = 24'h300000;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b1;
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_p", {8'd0, p}, 32'd0);
        run_op("post_rst", 24'h100000, 24'h300000, 24'h155555, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opti_divider.md
OPTI_DIVIDER -- requirements
Module: opti_divider

Interface
REQ-001 SHALL declare no parameters; format fixed at Q2.22 signed, saturation limits Q22_MAX = 24'h3FFFFF, Q22_MIN = 24'hC00000.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset: one clock; synchronous, active-low.
REQ-004 SHALL have a  input  24  signed dividend, Q2.22.
REQ-005 SHALL have b  input  24  signed divisor, Q2.22.
REQ-006 SHALL have valid_in  input  1  request strobe; a/b sampled when valid_in && ready.
REQ-007 SHALL have ready  output  1  high iff FSM in IDLE (combinational from state).
REQ-008 SHALL have p  output  24  signed quotient a/b, Q2.22, registered.
REQ-009 SHALL have valid_out  output  1  one-cycle pulse marking p valid.
REQ-010 SHALL have div_zero  output  1  registered; qualifies p, 1 when b was zero.

Function
REQ-011 SHALL implement FSM IDLE -> PREP -> DIV -> ROUND -> IDLE; IDLE exits only on valid_in && ready.
REQ-012 On accept SHALL register a, b, result sign = a[23]^b[23], |a| and |b| as 24-bit unsigned (|0x800000| = 2^23).
REQ-013 PREP (1 cycle) SHALL flag zero (b==0) and overflow (|a| >= 4*|b|, 26-bit compare), and load the 5-bit iteration counter.
REQ-014 DIV SHALL run exactly 25 radix-2 restoring iterations, one per cycle, producing Q25 = floor(|a|*2^23/|b|); iterations run even when zero/overflow flagged (fixed latency).
REQ-015 ROUND SHALL form magnitude Qm = (Q25+1)>>1 (round half away from zero), apply sign, saturate: positive and Qm > 0x3FFFFF -> 0x3FFFFF; negative and Qm > 0x400000 -> 0xC00000; overflow flag -> limit by sign.
REQ-016 Zero divisor SHALL give p = 0x3FFFFF if a >= 0 else 0xC00000, div_zero = 1; otherwise div_zero = 0.
REQ-017 Zero dividend with nonzero b SHALL give p = 0x000000, regardless of sign.
REQ-018 Latency: accept at edge k -> p, div_zero updated and valid_out = 1 after edge k+27, valid_out = 0 after edge k+28.
REQ-019 ready SHALL return high after edge k+27; earliest next accept at edge k+28 (one operation per 28 cycles).
REQ-020 valid_in while ready = 0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-021 p and div_zero SHALL hold their last values between valid_out pulses.
REQ-022 Input a/b changes after accept SHALL not affect the result.

Reset
REQ-023 rst_n sampled low at an edge SHALL force IDLE, counter 0, p = 0, div_zero = 0, valid_out = 0, all datapath registers 0; ready = 1 from the next cycle.
REQ-024 Reset during PREP/DIV/ROUND SHALL abort the operation with no valid_out for it; first accept allowed at the first edge with rst_n high.
REQ-025 Reset held low SHALL take priority over valid_in.

Verification
REQ-026 a=0x200000 (0.5), b=0x400000 (1.0) -> valid_out exactly 27 cycles after accept, p=0x200000, div_zero=0.
REQ-027 a=0x100000, b=0xC00000 -> p=0xF00000 (-0.25); a=0x200000, b=0x300000 -> p=0x2AAAAB (round-up); a=0x100000, b=0x300000 -> p=0x155555 (round-down).
REQ-028 a=0x400000, b=0x200000 -> p=0x3FFFFF, div_zero=0; a=0x400000, b=0xC00000 -> p=0xC00000 (exact -1.0, no saturation flag path); a=0x800000, b=0x000001 -> p=0xC00000.
REQ-029 a=0xE00000, b=0 -> p=0xC00000, div_zero=1; a=0, b=0 -> p=0x3FFFFF, div_zero=1.
REQ-030 valid_in held high continuously with changing a/b -> accepts only at IDLE edges, one valid_out per 28 cycles, each result matching its accepted operands.
REQ-031 rst_n low for 1 cycle at DIV iteration 10 -> no valid_out, p=0; new request then completes with correct p after 27 cycles.
